// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the I-cache/D-cache main-memory
//               arbiter: FSM state encoding, default widths and last-grant codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Default widths: 28-bit block address, 128-bit (4-word) cache line
    localparam int c_addr_w = 28;
    localparam int c_data_w = 128;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

    // Encodings of the side that most recently received a grant
    localparam logic c_last_gnt_i = 1'b0;
    localparam logic c_last_gnt_d = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single main-memory port between the I-cache and the
//               D-cache. Whole transactions are granted to one owner at a time
//               and held until mem_ready; contention is resolved round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    // I-cache side
    input  logic              ic_mem_read,
    input  logic              ic_mem_write,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    input  logic [DATA_W-1:0] ic_mem_wdata,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    // D-cache side
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    // Main-memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_gnt;
    logic       w_next_last_gnt;
    logic       w_req_i;
    logic       w_req_d;

    assign w_req_i = ic_mem_read | ic_mem_write;
    assign w_req_d = dc_mem_read | dc_mem_write;

    // Read data goes to both caches; only the ready strobe identifies the owner
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;

    // Next-state and last-grant selection; contention goes to the side not served last
    always_comb begin
        w_next_state    = r_state;
        w_next_last_gnt = r_last_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req_i && w_req_d) begin
                    if (r_last_gnt == c_last_gnt_i) begin
                        w_next_state    = ST_GNT_D;
                        w_next_last_gnt = c_last_gnt_d;
                    end else begin
                        w_next_state    = ST_GNT_I;
                        w_next_last_gnt = c_last_gnt_i;
                    end
                end else if (w_req_d) begin
                    w_next_state    = ST_GNT_D;
                    w_next_last_gnt = c_last_gnt_d;
                end else if (w_req_i) begin
                    w_next_state    = ST_GNT_I;
                    w_next_last_gnt = c_last_gnt_i;
                end
            end
            // Completion or a withdrawn request both release the port; the
            // mandatory IDLE cycle keeps a just-finished request from being re-granted
            ST_GNT_I: begin
                if (mem_ready || !w_req_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_GNT_D: begin
                if (mem_ready || !w_req_d) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State and last-grant registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= c_last_gnt_i;
        end else begin
            r_state    <= w_next_state;
            r_last_gnt <= w_next_last_gnt;
        end
    end

    // Flat output mux on state; everything is quiet while idle or held in reset,
    // and memory controls drop immediately if the owner withdraws its request
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ic_mem_ready = 1'b0;
        dc_mem_ready = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_GNT_I: begin
                    if (w_req_i) begin
                        mem_read  = ic_mem_read;
                        mem_write = ic_mem_write;
                        mem_addr  = ic_mem_addr;
                        mem_wdata = ic_mem_wdata;
                    end
                    ic_mem_ready = mem_ready;
                end
                ST_GNT_D: begin
                    if (w_req_d) begin
                        mem_read  = dc_mem_read;
                        mem_write = dc_mem_write;
                        mem_addr  = dc_mem_addr;
                        mem_wdata = dc_mem_wdata;
                    end
                    dc_mem_ready = mem_ready;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire
